// File: rtl/fu_arbiter.sv
// Round-robin arbiter that lends one combinational function unit to NREQ requesters.
// Only one transaction is in flight at a time. Operands are registered toward the fu, and the result is registered on the way back.
module fu_arbiter #(
    parameter  int NREQ = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*4-1:0]    req_fs,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*16-1:0]   req_b,
    output logic [3:0]           fu_fs,
    output logic [15:0]          fu_a,
    output logic [15:0]          fu_b,
    input  logic [15:0]          fu_f,
    input  logic                 fu_z,
    input  logic                 fu_n,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_f,
    output logic                 rsp_z,
    output logic                 rsp_n,
    output logic                 busy
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [3:0]       fu_fs_q, fu_fs_d;
    logic [15:0]      fu_a_q, fu_a_d;
    logic [15:0]      fu_b_q, fu_b_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [15:0]      rsp_f_q, rsp_f_d;
    logic             rsp_z_q, rsp_z_d;
    logic             rsp_n_q, rsp_n_d;

    logic [3:0]       fs_arr [NREQ];
    logic [15:0]      a_arr  [NREQ];
    logic [15:0]      b_arr  [NREQ];

    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;
    logic             accept_window;
    logic             accept;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign fs_arr[gi] = req_fs[4*gi +: 4];
            assign a_arr[gi]  = req_a[16*gi +: 16];
            assign b_arr[gi]  = req_b[16*gi +: 16];
        end
    endgenerate

    // Search starts at rr_ptr and wraps, so the requester granted last time gets the lowest priority.
    always_comb begin
        int             cand;
        logic [IDW-1:0] cand_idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IDW'(cand);
            if (!gnt_found && req_valid[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    // Consuming a response in RESP frees the unit in the same cycle, so a new grant can be issued immediately.
    assign accept_window = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
    assign accept        = accept_window && gnt_found;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = accept && (gnt_idx == IDW'(gi));
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        fu_fs_d  = fu_fs_q;
        fu_a_d   = fu_a_q;
        fu_b_d   = fu_b_q;
        rsp_id_d = rsp_id_q;
        rsp_f_d  = rsp_f_q;
        rsp_z_d  = rsp_z_q;
        rsp_n_d  = rsp_n_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_RESP;
                rsp_f_d = fu_f;
                rsp_z_d = fu_z;
                rsp_n_d = fu_n;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = accept ? S_EXEC : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            fu_fs_d  = fs_arr[gnt_idx];
            fu_a_d   = a_arr[gnt_idx];
            fu_b_d   = b_arr[gnt_idx];
            rsp_id_d = gnt_idx;
            rr_ptr_d = (gnt_idx == LAST_ID) ? '0 : gnt_idx + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            fu_fs_q  <= 4'b0000;
            fu_a_q   <= '0;
            fu_b_q   <= '0;
            rsp_id_q <= '0;
            rsp_f_q  <= '0;
            rsp_z_q  <= 1'b0;
            rsp_n_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            fu_fs_q  <= fu_fs_d;
            fu_a_q   <= fu_a_d;
            fu_b_q   <= fu_b_d;
            rsp_id_q <= rsp_id_d;
            rsp_f_q  <= rsp_f_d;
            rsp_z_q  <= rsp_z_d;
            rsp_n_q  <= rsp_n_d;
        end
    end

    assign fu_fs     = fu_fs_q;
    assign fu_a      = fu_a_q;
    assign fu_b      = fu_b_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_f     = rsp_f_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_n     = rsp_n_q;
    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);

endmodule
